// File: rtl/cobalt_pkg.sv
// Shared constants and state encoding for the tag free-list FIFO.
package cobalt_pkg;

  localparam int W_TAG = 6;
  localparam int N_TAG = 2 ** W_TAG;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tag_fifo_state_e;

endpackage

// File: rtl/tag_fifo_mem.sv
// Tag storage: one synchronous write port, one asynchronous read port, no reset.
module tag_fifo_mem #(
  parameter int W_TAG = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [W_TAG-1:0] waddr_i,
  input  logic [W_TAG-1:0] wdata_i,
  input  logic [W_TAG-1:0] raddr_i,
  output logic [W_TAG-1:0] rdata_o
);

  localparam int N_TAG = 2 ** W_TAG;

  logic [W_TAG-1:0] mem_q [N_TAG];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tag_fifo.sv
// Free-tag FIFO: self-initialises with tags 0..N_TAG-1, hands tags to dispatch,
// and takes freed tags back from the CDB.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | writing mem[k]=k one per cycle; outputs not ready
// ST_RUN  | normal free-list operation (pop to dispatch, push from CDB)
module tag_fifo
  import cobalt_pkg::*;
#(
  parameter int W_TAG = cobalt_pkg::W_TAG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic [W_TAG-1:0] dispatch_tag,
  output logic             dispatch_tag_valid,
  input  logic             dispatch_tag_pop,
  input  logic [W_TAG-1:0] cdb_tag,
  input  logic             cdb_valid,
  output logic [W_TAG:0]   fifo_count,
  output logic             fifo_ready,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int N_TAG = 2 ** W_TAG;
  localparam logic [W_TAG:0] FULL_CNT = (W_TAG + 1)'(N_TAG);

  tag_fifo_state_e  state_q, state_d;
  logic [W_TAG:0]   k_q, k_d;
  logic [W_TAG-1:0] head_q, head_d;
  logic [W_TAG-1:0] tail_q, tail_d;
  logic [W_TAG:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [W_TAG-1:0] mem_waddr;
  logic [W_TAG-1:0] mem_wdata;
  logic             pop_ok;
  logic             push_ok;

  tag_fifo_mem #(.W_TAG(W_TAG)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (head_q),
    .rdata_o (dispatch_tag)
  );

  assign fifo_ready         = (state_q == ST_RUN);
  assign dispatch_tag_valid = fifo_ready && (count_q != '0);
  assign fifo_count         = count_q;
  assign err_overflow       = ovf_q;
  assign err_underflow      = unf_q;

  // A pop frees a slot, so a full FIFO can still accept a push in the same cycle.
  assign pop_ok  = dispatch_tag_pop && dispatch_tag_valid;
  assign push_ok = fifo_ready && cdb_valid && ((count_q != FULL_CNT) || pop_ok);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = tail_q;
    mem_wdata = cdb_tag;

    unique case (state_q)
      ST_INIT: begin
        if (cdb_valid) ovf_d = 1'b1;
        if (k_q == FULL_CNT) begin
          state_d = ST_RUN;
          head_d  = '0;
          tail_d  = '0;
          count_d = FULL_CNT;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = k_q[W_TAG-1:0];
          mem_wdata = k_q[W_TAG-1:0];
          k_d       = k_q + 1'b1;
        end
        if (flush) begin
          state_d = ST_INIT;
          k_d     = '0;
          count_d = '0;
        end
      end

      ST_RUN: begin
        if (flush) begin
          state_d = ST_INIT;
          k_d     = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end else begin
          if (dispatch_tag_pop && !dispatch_tag_valid) unf_d = 1'b1;
          if (cdb_valid && !push_ok) ovf_d = 1'b1;
          if (push_ok) begin
            mem_we = 1'b1;
            tail_d = tail_q + 1'b1;
          end
          if (pop_ok) head_d = head_q + 1'b1;
          unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      k_q     <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: doc/tag_fifo.md
TAG_FIFO -- requirements
Module: tag_fifo

Interface
REQ-001 SHALL have parameter W_TAG, default 6, meaning tag width.
REQ-002 SHALL have derived constant N_TAG = 2**W_TAG (64), meaning total tags in circulation.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 SHALL have port flush  input  1  synchronous recovery request that returns all tags to the free list.
REQ-006 SHALL have port dispatch_tag  output  W_TAG  tag at the FIFO head, offered to dispatch (and from there to the register status table).
REQ-007 SHALL have port dispatch_tag_valid  output  1  head tag is valid and may be popped.
REQ-008 SHALL have port dispatch_tag_pop  input  1  dispatch consumes the head tag this cycle.
REQ-009 SHALL have port cdb_tag  input  W_TAG  tag freed by a CDB broadcast.
REQ-010 SHALL have port cdb_valid  input  1  cdb_tag is valid and shall be pushed.
REQ-011 SHALL have port fifo_count  output  W_TAG+1  number of free tags held.
REQ-012 SHALL have port fifo_ready  output  1  initialisation is complete (state RUN).
REQ-013 SHALL have port err_overflow  output  1  sticky flag: a push was dropped.
REQ-014 SHALL have port err_underflow  output  1  sticky flag: a pop was ignored.

Function
REQ-015 SHALL implement FSM states INIT and RUN.
REQ-016 INIT behaviour: write mem[k]=k for one k per cycle, k = 0..N_TAG-1; on the cycle after k = N_TAG-1 is written, go to RUN with head=0, tail=0, count=N_TAG.
REQ-017 INIT outputs: fifo_ready=0 and dispatch_tag_valid=0; pops are ignored without setting an error; pushes are dropped and set err_overflow.
REQ-018 In RUN, flush=1 SHALL re-enter INIT on the next cycle with k=0. Flush during INIT restarts k at 0. Flush SHALL NOT clear the sticky error flags.
REQ-019 dispatch_tag SHALL equal mem[head], read combinationally from registered storage (zero-cycle offer).
REQ-020 dispatch_tag_valid SHALL equal (state==RUN && count!=0).
REQ-021 Pop occurs when dispatch_tag_pop && dispatch_tag_valid: head advances by 1 modulo N_TAG on the next edge.
REQ-022 Push occurs when cdb_valid in RUN and (count<N_TAG or a pop also occurs this cycle): mem[tail]=cdb_tag, and tail advances by 1 modulo N_TAG.
REQ-023 Count update: count += push - pop, with no intermediate wrap; width W_TAG+1 holds the value N_TAG.
REQ-024 Push-to-head latency SHALL be 1 cycle: a tag pushed into an empty FIFO at edge t is offered with valid=1 after edge t.
REQ-025 Empty with push and pop in the same cycle: the pop is ignored and sets err_underflow; the push is accepted; count becomes 1. There is no bypass.
REQ-026 Full with push and pop in the same cycle: both are accepted; count stays N_TAG; no error.
REQ-027 Full with push and no pop: the push is dropped and err_overflow is set.
REQ-028 dispatch_tag_pop while dispatch_tag_valid=0 in RUN SHALL set err_underflow.
REQ-029 head and tail SHALL wrap from N_TAG-1 to 0.

Reset
REQ-030 While reset=0, asynchronously: state=INIT, k=0, head=0, tail=0, count=0, err_overflow=0, err_underflow=0. Resulting outputs: fifo_ready=0, dispatch_tag_valid=0, fifo_count=0.
REQ-031 Storage mem SHALL NOT be reset; INIT defines its contents.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight state; after release, RUN is reached N_TAG+1 cycles later.

Structure
REQ-033 W_TAG and N_TAG SHALL live in the shared package cobalt_pkg, alongside the FSM state enum for tag_fifo.
REQ-034 Storage SHALL be a sub-module tag_fifo_mem: N_TAG x W_TAG, one write port, one asynchronous read port, no reset.

Verification
REQ-035 Reset release, then wait 65 cycles -> fifo_ready=1, fifo_count=64, dispatch_tag=0, valid=1.
REQ-036 Pop 64 consecutive cycles -> tags 0..63 in order, then valid=0, count=0, no errors.
REQ-037 Empty, then push cdb_tag=0x2A -> next cycle dispatch_tag=0x2A, valid=1, count=1.
REQ-038 Empty, pop and push 0x05 in the same cycle -> err_underflow=1, count=1, dispatch_tag=0x05.
REQ-039 Full, push 0x11 alone -> err_overflow=1, count=64; full, pop and push 0x11 together -> count=64, tag 0x11 appears at position 64 after wrap.
REQ-040 Pop 10 times, then flush -> fifo_ready=0 for 65 cycles, then count=64 and head tag=0; reset=0 mid-INIT -> outputs zero immediately, asynchronously.
